// File: rtl/hazard_fwd_ctrl_pkg.sv
// rtl/hazard_fwd_ctrl_pkg.sv - forwarding select codes and stage record layout
package hazard_fwd_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_MO  = 2'b11;

  // Stage record {wreg, m2reg, wz, rn}: flag bit offsets above the rn field.
  localparam int REC_FLAGS = 3;
  localparam int OFS_WREG  = 2;
  localparam int OFS_M2REG = 1;
  localparam int OFS_WZ    = 0;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// rtl/hazard_fwd_ctrl_fwd_sel.sv - operand forwarding select for one ID source
module hazard_fwd_ctrl_fwd_sel
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RN_W = 5
) (
  input  logic [RN_W-1:0] src,
  input  logic            use_src,
  input  logic            e_wreg,
  input  logic            e_m2reg,
  input  logic [RN_W-1:0] e_rn,
  input  logic            m_wreg,
  input  logic            m_m2reg,
  input  logic [RN_W-1:0] m_rn,
  output logic [1:0]      sel
);

  logic e_hit;
  logic m_hit;

  assign e_hit = e_wreg & (e_rn == src) & (src != '0);
  assign m_hit = m_wreg & (m_rn == src) & (src != '0);

  // A load in E cannot forward yet; it falls through to M (or stalls upstream).
  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (e_hit && !e_m2reg) begin
        sel = FWD_EXE;
      end else if (m_hit) begin
        sel = m_m2reg ? FWD_MO : FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - ID-stage hazard, stall, bubble and forwarding control
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int RN_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [RN_W-1:0]  id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wz,
  input  logic             id_usez,
  input  logic             stall_ext,
  output logic             wpcir,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int REC_W = RN_W + REC_FLAGS;

  logic [REC_W-1:0]  e_rec;
  // Z is captured by EXE/MEM itself, so the M copy carries no wz flag.
  logic [RN_W+1:0]   m_rec;
  logic              e_wreg, e_m2reg, e_wz, m_wreg, m_m2reg;
  logic [RN_W-1:0]   e_rn, m_rn;
  logic              rs_hit_e, rt_hit_e, lu_stall, z_stall, hz;

  assign e_wreg  = e_rec[RN_W+OFS_WREG];
  assign e_m2reg = e_rec[RN_W+OFS_M2REG];
  assign e_wz    = e_rec[RN_W+OFS_WZ];
  assign e_rn    = e_rec[RN_W-1:0];
  assign m_wreg  = m_rec[RN_W+1];
  assign m_m2reg = m_rec[RN_W];
  assign m_rn    = m_rec[RN_W-1:0];

  assign rs_hit_e = e_wreg & (e_rn == id_rs) & (id_rs != '0);
  assign rt_hit_e = e_wreg & (e_rn == id_rt) & (id_rt != '0);
  assign lu_stall = e_m2reg & ((id_use_rs & rs_hit_e) | (id_use_rt & rt_hit_e));
  assign z_stall  = id_usez & e_wz;
  assign hz       = lu_stall | z_stall;

  hazard_fwd_ctrl_fwd_sel #(.RN_W(RN_W)) u_fwd_a (
    .src     (id_rs),
    .use_src (id_use_rs),
    .e_wreg  (e_wreg),
    .e_m2reg (e_m2reg),
    .e_rn    (e_rn),
    .m_wreg  (m_wreg),
    .m_m2reg (m_m2reg),
    .m_rn    (m_rn),
    .sel     (fwda)
  );

  hazard_fwd_ctrl_fwd_sel #(.RN_W(RN_W)) u_fwd_b (
    .src     (id_rt),
    .use_src (id_use_rt),
    .e_wreg  (e_wreg),
    .e_m2reg (e_m2reg),
    .e_rn    (e_rn),
    .m_wreg  (m_wreg),
    .m_m2reg (m_m2reg),
    .m_rn    (m_rn),
    .sel     (fwdb)
  );

  // An external freeze holds the whole pipe, so no bubble is injected.
  always_comb begin
    wpcir  = 1'b1;
    bubble = 1'b0;
    if (stall_ext) begin
      wpcir = 1'b0;
    end else if (hz) begin
      wpcir  = 1'b0;
      bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_rec <= '0;
      m_rec <= '0;
    end else if (!stall_ext) begin
      m_rec <= {e_wreg, e_m2reg, e_rn};
      e_rec <= hz ? '0 : {id_wreg, id_m2reg, id_wz, id_rn};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (!wpcir && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed table plus randomized model check of hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  logic       clk, clrn;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wz, id_usez, stall_ext;
  logic       wpcir, bubble;
  logic [1:0] fwda, fwdb;
  logic [15:0] stall_cnt;
  logic       s_wpcir, s_bubble;
  logic [1:0] s_fwda, s_fwdb, s_cnt;

  int total = 0;
  int bad = 0;

  hazard_fwd_ctrl #(.RN_W(5), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wz(id_wz), .id_usez(id_usez), .stall_ext(stall_ext), .wpcir(wpcir),
    .bubble(bubble), .fwda(fwda), .fwdb(fwdb), .stall_cnt(stall_cnt)
  );

  hazard_fwd_ctrl #(.RN_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wz(id_wz), .id_usez(id_usez), .stall_ext(stall_ext), .wpcir(s_wpcir),
    .bubble(s_bubble), .fwda(s_fwda), .fwdb(s_fwdb), .stall_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ext, rs, urs, rt, urt, rn, wreg, m2reg, wz, usez;
    int wp, bb, fa, fb, cnt;
  } vec_t;

  typedef struct {
    bit w, m, z;
    int rn;
  } mrec_t;

  vec_t  vecs[22];
  mrec_t m_e, m_m;
  int    mcnt, mcnt2;
  bit    m_wp, m_bb, m_hz;
  logic [1:0] m_fa, m_fb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mhit(input int x, input mrec_t r);
    return r.w && (r.rn == x) && (x != 0);
  endfunction

  function automatic logic [1:0] msel(input int x, input bit u);
    if (!u) return 2'd0;
    if (mhit(x, m_e) && !m_e.m) return 2'd1;
    if (mhit(x, m_m)) return m_m.m ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic eval_model();
    bit lu, zs;
    lu = (id_use_rs && mhit(int'(id_rs), m_e) && m_e.m) ||
         (id_use_rt && mhit(int'(id_rt), m_e) && m_e.m);
    zs = id_usez && m_e.z;
    m_hz = lu || zs;
    m_fa = msel(int'(id_rs), id_use_rs);
    m_fb = msel(int'(id_rt), id_use_rt);
    m_wp = !(stall_ext || m_hz);
    m_bb = !stall_ext && m_hz;
  endtask

  task automatic model_reset();
    m_e = '{0, 0, 0, 0};
    m_m = '{0, 0, 0, 0};
    mcnt = 0;
    mcnt2 = 0;
  endtask

  task automatic tick();
    eval_model();
    @(posedge clk);
    if (!stall_ext) begin
      m_m = m_e;
      if (m_hz) m_e = '{0, 0, 0, 0};
      else m_e = '{id_wreg, id_m2reg, id_wz, int'(id_rn)};
    end
    if (!m_wp) begin
      if (mcnt < 65535) mcnt++;
      if (mcnt2 < 3) mcnt2++;
    end
    #1;
  endtask

  task automatic set_id(input vec_t v);
    stall_ext = v.ext[0];
    id_rs = 5'(v.rs);
    id_use_rs = v.urs[0];
    id_rt = 5'(v.rt);
    id_use_rt = v.urt[0];
    id_rn = 5'(v.rn);
    id_wreg = v.wreg[0];
    id_m2reg = v.m2reg[0];
    id_wz = v.wz[0];
    id_usez = v.usez[0];
  endtask

  function automatic logic [31:0] exp_of(input vec_t v);
    return 32'((v.wp << 5) | (v.bb << 4) | (v.fa << 2) | v.fb);
  endfunction

  initial begin
    vec_t z;
    //         ext rs urs rt urt rn w  m  wz usez  wp bb fa fb cnt
    vecs[0]  = '{0, 1, 1, 2, 1, 3, 1, 0, 0, 0,  1, 0, 0, 0, 0};
    vecs[1]  = '{0, 3, 1, 4, 1, 7, 1, 0, 0, 0,  1, 0, 1, 0, 0};
    vecs[2]  = '{0, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 5, 1, 1, 0, 0,  1, 0, 0, 0, 0};
    vecs[4]  = '{0, 6, 1, 5, 1, 8, 1, 0, 0, 0,  0, 1, 0, 0, 0};
    vecs[5]  = '{0, 6, 1, 5, 1, 8, 1, 0, 0, 0,  1, 0, 0, 3, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 9, 1, 0, 1, 0,  1, 0, 0, 0, 1};
    vecs[11] = '{0, 2, 1, 9, 1, 0, 0, 0, 0, 1,  0, 1, 0, 1, 1};
    vecs[12] = '{0, 2, 1, 9, 1, 0, 0, 0, 0, 1,  1, 0, 0, 2, 2};
    vecs[13] = '{0, 0, 0, 0, 0, 5, 1, 1, 0, 0,  1, 0, 0, 0, 2};
    vecs[14] = '{1, 6, 1, 5, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 2};
    vecs[15] = '{1, 6, 1, 5, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 3};
    vecs[16] = '{1, 6, 1, 5, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 4};
    vecs[17] = '{0, 6, 1, 5, 1, 8, 1, 0, 0, 0,  0, 1, 0, 0, 5};
    vecs[18] = '{0, 6, 1, 5, 1, 8, 1, 0, 0, 0,  1, 0, 0, 3, 6};
    vecs[19] = '{0, 0, 0, 0, 0, 5, 1, 1, 1, 0,  1, 0, 0, 0, 6};
    vecs[20] = '{0, 5, 1, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 6};
    vecs[21] = '{0, 5, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 3, 0, 7};

    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    clrn = 1'b0;
    set_id(z);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 32'({wpcir, bubble, fwda, fwdb}), 32'h20);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    clrn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      set_id(vecs[i]);
      #3;
      chk($sformatf("vec%0d_out", i), 32'({wpcir, bubble, fwda, fwdb}), exp_of(vecs[i]));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_sat", i), 32'(s_cnt), 32'((vecs[i].cnt > 3) ? 3 : vecs[i].cnt));
      tick();
    end

    // Reset asserted in the middle of a load-use stall.
    set_id('{0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0});
    tick();
    set_id('{0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    #2;
    chk("pre_rst_stall", 32'({wpcir, bubble}), 32'h1);
    clrn = 1'b0;
    #1;
    chk("rst_async_out", 32'({wpcir, bubble, fwda, fwdb}), 32'h20);
    chk("rst_async_cnt", 32'({stall_cnt, s_cnt}), 32'd0);
    #2;
    clrn = 1'b1;
    model_reset();
    #1;
    chk("post_rst_out", 32'({wpcir, bubble, fwda, fwdb}), 32'h20);
    tick();
    chk("post_rst_next", 32'({wpcir, bubble, fwda, fwdb}), 32'h20);

    for (int i = 0; i < 300; i++) begin
      stall_ext = ($urandom_range(0, 7) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_rn = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      id_wreg = 1'($urandom);
      id_m2reg = 1'($urandom);
      id_wz = 1'($urandom);
      id_usez = ($urandom_range(0, 3) == 0);
      #3;
      eval_model();
      chk("rnd_out", 32'({wpcir, bubble, fwda, fwdb}), 32'({m_wp, m_bb, m_fa, m_fb}));
      chk("rnd_cnt", 32'(stall_cnt), 32'(mcnt));
      chk("rnd_sat", 32'({s_wpcir, s_bubble, s_fwda, s_fwdb, s_cnt}),
          32'({m_wp, m_bb, m_fa, m_fb, 2'(mcnt2)}));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
